// File: rtl/deserializer.sv
// rtl/deserializer.sv - serial packet receiver: head-byte frame alignment, XOR checksum, 2-phase req/ack delivery
// deserializer_csum folds the three header/payload bytes into the expected checksum byte.

module deserializer_csum (
  input  logic [31:0] i_frame,
  output logic [7:0]  o_csum,
  output logic        o_match
);
  assign o_csum  = i_frame[31:24] ^ i_frame[23:16] ^ i_frame[15:8];
  assign o_match = (i_frame[7:0] == o_csum);
endmodule

module deserializer #(
  parameter logic [7:0] HEAD_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  input  logic        en,
  output logic        req,
  input  logic        ack,
  output logic [31:0] data,
  output logic        locked,
  output logic        crc_err,
  output logic        ovf
);

  typedef enum logic {
    S_HUNT = 1'b0,
    S_RECV = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_sr;
  logic [4:0]  r_bit_cnt;
  logic        r_req;
  logic        r_ack;
  logic [31:0] r_data;
  logic        r_locked;
  logic        r_crc_err;
  logic        r_ovf;

  logic [31:0] w_sr_nxt;
  logic [7:0]  w_csum;
  logic        w_crc_ok;
  logic        w_head_ok;
  logic        w_pending;
  logic        w_frame_end;

  // LSB-first stream: each new bit enters at the top, so after 32 samples the head sits in [31:24].
  assign w_sr_nxt    = {din, r_sr[31:1]};
  assign w_head_ok   = (w_sr_nxt[31:24] == HEAD_BYTE);
  assign w_pending   = r_req ^ r_ack;
  assign w_frame_end = (r_bit_cnt == 5'd31);

  deserializer_csum u_csum (
    .i_frame (w_sr_nxt),
    .o_csum  (w_csum),
    .o_match (w_crc_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_HUNT;
      r_sr      <= 32'd0;
      r_bit_cnt <= 5'd0;
      r_req     <= 1'b0;
      r_ack     <= 1'b0;
      r_data    <= 32'd0;
      r_locked  <= 1'b0;
      r_crc_err <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      // ack is registered unconditionally; an ack landing on a frame's last bit is seen one cycle late.
      r_ack     <= ack;
      r_crc_err <= 1'b0;
      r_ovf     <= 1'b0;
      if (en) begin
        r_sr <= w_sr_nxt;
        case (r_state)
          S_HUNT: begin
            if (w_head_ok && w_crc_ok) begin
              if (!w_pending) begin
                r_data <= w_sr_nxt;
                r_req  <= ~r_req;
              end else begin
                r_ovf <= 1'b1;
              end
              r_bit_cnt <= 5'd0;
              r_state   <= S_RECV;
              r_locked  <= 1'b1;
            end
          end
          S_RECV: begin
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (w_frame_end) begin
              if (!w_head_ok) begin
                r_state  <= S_HUNT;
                r_locked <= 1'b0;
              end else if (!w_crc_ok) begin
                r_crc_err <= 1'b1;
              end else if (!w_pending) begin
                r_data <= w_sr_nxt;
                r_req  <= ~r_req;
              end else begin
                r_ovf <= 1'b1;
              end
            end
          end
          default: begin
            r_state  <= S_HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign req     = r_req;
  assign data    = r_data;
  assign locked  = r_locked;
  assign crc_err = r_crc_err;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - directed bench for deserializer: lock, streaming, crc error, overflow, relock, reset, en gating

module tb_deserializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        din;
  logic        en;
  logic        ack;
  logic        req;
  logic [31:0] data;
  logic        locked;
  logic        crc_err;
  logic        ovf;

  localparam logic [31:0] F1   = 32'hA53C5AC3;
  localparam logic [31:0] F2   = 32'hA50100A4;
  localparam logic [31:0] F3   = 32'hA5FFFFA5;
  localparam logic [31:0] FBAD = 32'hA53C5A00;
  localparam logic [31:0] FOFF = 32'h00000000;

  deserializer #(.HEAD_BYTE(8'hA5)) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .en      (en),
    .req     (req),
    .ack     (ack),
    .data    (data),
    .locked  (locked),
    .crc_err (crc_err),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   crc_hi   = 0;
  int   ovf_hi   = 0;
  int   tog_t[$];
  logic last_req = 1'b0;
  logic auto_ack = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Monitor: req toggle times and pulse-high cycle counts, sampled 1ns after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (req !== last_req) begin
        tog_t.push_back(cyc);
        last_req = req;
      end
      if (crc_err === 1'b1) crc_hi++;
      if (ovf === 1'b1) ovf_hi++;
    end
  end

  // Consumer model: acks one half-cycle after seeing a new request.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_ack && (req !== ack)) ack = req;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    din = b;
    en  = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic send_bits(input logic [31:0] f, input int n);
    for (int i = 0; i < n; i++) send_bit(f[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en = 1'b0;
      @(posedge clk);
      #2;
    end
  endtask

  logic r0;
  int   n0;
  int   d1;
  int   d2;
  logic [4:0] rb;

  initial begin
    rst = 1'b1;
    din = 1'b0;
    en  = 1'b0;
    ack = 1'b0;
    #12;
    check("rst_req", {31'd0, req}, 32'd0);
    check("rst_data", data, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_crc_err", {31'd0, crc_err}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    auto_ack = 1'b1;

    // Lock and deliver
    send_bits(F1, 31);
    check("lock_req_before_bit32", {31'd0, req}, 32'd0);
    check("lock_locked_before", {31'd0, locked}, 32'd0);
    send_bit(F1[31]);
    check("lock_req", {31'd0, req}, 32'd1);
    check("lock_data", data, F1);
    check("lock_locked", {31'd0, locked}, 32'd1);

    // Streaming: three back-to-back frames
    n0 = tog_t.size();
    send_bits(F1, 32);
    check("stream_data1", data, F1);
    send_bits(F2, 32);
    check("stream_data2", data, F2);
    send_bits(F3, 32);
    check("stream_data3", data, F3);
    check("stream_toggles", tog_t.size() - n0, 32'd3);
    d1 = (tog_t.size() >= n0 + 3) ? tog_t[n0+1] - tog_t[n0]   : -1;
    d2 = (tog_t.size() >= n0 + 3) ? tog_t[n0+2] - tog_t[n0+1] : -1;
    check("stream_gap1", d1, 32'd32);
    check("stream_gap2", d2, 32'd32);
    check("stream_no_crc_err", crc_hi, 32'd0);
    check("stream_no_ovf", ovf_hi, 32'd0);

    // CRC error while locked
    r0 = req;
    send_bits(FBAD, 32);
    check("crc_pulse", {31'd0, crc_err}, 32'd1);
    check("crc_req_hold", {31'd0, req}, {31'd0, r0});
    check("crc_locked", {31'd0, locked}, 32'd1);
    check("crc_data_hold", data, F3);
    send_bits(F2, 32);
    check("crc_next_req", {31'd0, req}, {31'd0, ~r0});
    check("crc_next_data", data, F2);
    check("crc_pulse_width", crc_hi, 32'd1);

    // Overflow: withhold ack
    idle(1);
    auto_ack = 1'b0;
    send_bits(F1, 32);
    check("ovf_first_data", data, F1);
    r0 = req;
    send_bits(F2, 32);
    check("ovf_pulse", {31'd0, ovf}, 32'd1);
    check("ovf_data_hold", data, F1);
    check("ovf_req_hold", {31'd0, req}, {31'd0, r0});
    ack = req;
    send_bits(F3, 32);
    check("ovf_third_data", data, F3);
    check("ovf_third_req", {31'd0, req}, {31'd0, ~r0});
    check("ovf_pulse_width", ovf_hi, 32'd1);
    auto_ack = 1'b1;

    // Loss of lock and re-lock after 5 stray bits
    send_bits(FOFF, 32);
    check("unlock_locked", {31'd0, locked}, 32'd0);
    check("unlock_data_hold", data, F3);
    rb = 5'b01101;
    send_bits({27'd0, rb}, 5);
    check("hunt_locked", {31'd0, locked}, 32'd0);
    send_bits(F1, 31);
    check("relock_before", {31'd0, locked}, 32'd0);
    send_bit(F1[31]);
    check("relock_locked", {31'd0, locked}, 32'd1);
    check("relock_data", data, F1);

    // Async reset mid-frame
    send_bits(F3, 32);
    check("prerst_req", {31'd0, req}, 32'd1);
    check("prerst_data", data, F3);
    send_bits(F2, 17);
    auto_ack = 1'b0;
    #1;
    rst = 1'b1;
    ack = 1'b0;
    #1;
    check("arst_req", {31'd0, req}, 32'd0);
    check("arst_data", data, 32'd0);
    check("arst_locked", {31'd0, locked}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    auto_ack = 1'b1;

    // en gating: every other cycle disabled, with junk on din
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      din = F1[i];
      en  = 1'b1;
      @(posedge clk);
      #2;
      if (i == 30) check("engate_req_at31", {31'd0, req}, 32'd0);
      if (i == 31) begin
        check("engate_req", {31'd0, req}, 32'd1);
        check("engate_data", data, F1);
        check("engate_locked", {31'd0, locked}, 32'd1);
      end
      @(negedge clk);
      din = ~F1[i];
      en  = 1'b0;
      @(posedge clk);
      #2;
      if (i == 30) check("engate_hold_req", {31'd0, req}, 32'd0);
    end
    check("final_crc_cycles", crc_hi, 32'd1);
    check("final_ovf_cycles", ovf_hi, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
